// File: rtl/dbus_avm_bridge_if.sv
// Signal bundle between the CPU dBus port, the dBus-to-Avalon bridge and the Avalon-MM fabric.
// The bridge uses the master view (it masters Avalon); the CPU/fabric side uses the slave view.
interface dbus_avm_bridge_if;
  logic        dBus_cmd_valid;
  logic        dBus_cmd_ready;
  logic        dBus_cmd_payload_wr;
  logic [31:0] dBus_cmd_payload_address;
  logic [31:0] dBus_cmd_payload_data;
  logic [1:0]  dBus_cmd_payload_size;
  logic        dBus_rsp_ready;
  logic        dBus_rsp_error;
  logic [31:0] dBus_rsp_data;
  logic        avm_data_read;
  logic        avm_data_write;
  logic        avm_data_waitrequest;
  logic [31:0] avm_data_address;
  logic [3:0]  avm_data_byteenable;
  logic [31:0] avm_data_writedata;
  logic        avm_data_readdatavalid;
  logic [31:0] avm_data_readdata;
  logic [1:0]  avm_data_response;

  modport master (
    input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
           dBus_cmd_payload_data, dBus_cmd_payload_size,
    output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
    output avm_data_read, avm_data_write, avm_data_address, avm_data_byteenable,
           avm_data_writedata,
    input  avm_data_waitrequest, avm_data_readdatavalid, avm_data_readdata,
           avm_data_response
  );

  modport slave (
    output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
           dBus_cmd_payload_data, dBus_cmd_payload_size,
    input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
    input  avm_data_read, avm_data_write, avm_data_address, avm_data_byteenable,
           avm_data_writedata,
    output avm_data_waitrequest, avm_data_readdatavalid, avm_data_readdata,
           avm_data_response
  );
endinterface

// File: rtl/dbus_avm_bridge.sv
// CPU dBus responder issuing Avalon-MM master cycles: byte-enable decode, waitrequest
// stalls, pipelined reads with a bounded outstanding count, in-order misalignment errors.
module dbus_avm_bridge #(
  parameter int MAX_PENDING = 4
) (
  input  logic              clk_cpu,
  input  logic              clk_cpu_reset_,
  dbus_avm_bridge_if.master bus
);
  localparam logic [3:0] MaxPend = 4'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, ISSUE, ERR_DRAIN, ERR_RSP} stateE;
  stateE state, stateNxt;

  logic [29:0] addrQ;
  logic [31:0] dataQ;
  logic [3:0]  beQ;
  logic        wrQ;
  logic [3:0]  pending;
  logic        rspReadyQ, rspErrorQ;
  logic [31:0] rspDataQ;
  logic        accept, legal;
  logic [3:0]  beDec;
  logic        rdAccept, rdReturn;

  assign bus.dBus_cmd_ready = clk_cpu_reset_ & (state == IDLE) & (pending < MaxPend);
  assign accept             = bus.dBus_cmd_valid & bus.dBus_cmd_ready;

  always_comb begin
    legal = 1'b0;
    beDec = 4'b0000;
    case (bus.dBus_cmd_payload_size)
      2'd0: begin
        legal = 1'b1;
        beDec = 4'b0001 << bus.dBus_cmd_payload_address[1:0];
      end
      2'd1: begin
        legal = ~bus.dBus_cmd_payload_address[0];
        beDec = bus.dBus_cmd_payload_address[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        legal = (bus.dBus_cmd_payload_address[1:0] == 2'b00);
        beDec = 4'b1111;
      end
      default: ;
    endcase
  end

  // Illegal writes are dropped in IDLE; illegal reads wait for older reads to retire.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (legal)                         stateNxt = ISSUE;
          else if (!bus.dBus_cmd_payload_wr) stateNxt = ERR_DRAIN;
        end
      end
      ISSUE:     if (!bus.avm_data_waitrequest) stateNxt = IDLE;
      ERR_DRAIN: if (pending == 4'd0)          stateNxt = ERR_RSP;
      ERR_RSP:   stateNxt = IDLE;
      default:   stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu or negedge clk_cpu_reset_) begin
    if (!clk_cpu_reset_) state <= IDLE;
    else                 state <= stateNxt;
  end

  always_ff @(posedge clk_cpu or negedge clk_cpu_reset_) begin
    if (!clk_cpu_reset_) begin
      addrQ <= '0;
      dataQ <= '0;
      beQ   <= '0;
      wrQ   <= 1'b0;
    end else if (accept && legal) begin
      addrQ <= bus.dBus_cmd_payload_address[31:2];
      dataQ <= bus.dBus_cmd_payload_data;
      beQ   <= beDec;
      wrQ   <= bus.dBus_cmd_payload_wr;
    end
  end

  assign bus.avm_data_read       = (state == ISSUE) & ~wrQ;
  assign bus.avm_data_write      = (state == ISSUE) &  wrQ;
  assign bus.avm_data_address    = {addrQ, 2'b00};
  assign bus.avm_data_byteenable = beQ;
  assign bus.avm_data_writedata  = dataQ;

  // Returns with nothing outstanding (e.g. reads orphaned by a reset) are discarded.
  assign rdAccept = bus.avm_data_read & ~bus.avm_data_waitrequest;
  assign rdReturn = bus.avm_data_readdatavalid & (pending != 4'd0);

  always_ff @(posedge clk_cpu or negedge clk_cpu_reset_) begin
    if (!clk_cpu_reset_) pending <= 4'd0;
    else                 pending <= pending + {3'b000, rdAccept} - {3'b000, rdReturn};
  end

  always_ff @(posedge clk_cpu or negedge clk_cpu_reset_) begin
    if (!clk_cpu_reset_) begin
      rspReadyQ <= 1'b0;
      rspErrorQ <= 1'b0;
      rspDataQ  <= '0;
    end else begin
      rspReadyQ <= rdReturn;
      rspErrorQ <= rdReturn & (bus.avm_data_response != 2'b00);
      rspDataQ  <= rdReturn ? bus.avm_data_readdata : 32'h0;
    end
  end

  // ERR_RSP is only reached a cycle after the last return, so it never overlaps rspReadyQ.
  assign bus.dBus_rsp_ready = rspReadyQ | (state == ERR_RSP);
  assign bus.dBus_rsp_error = rspErrorQ | (state == ERR_RSP);
  assign bus.dBus_rsp_data  = rspDataQ;
endmodule

// File: tb/tb_dbus_avm_bridge.sv
// Scoreboard bench for dbus_avm_bridge: CPU driver with a reference memory model,
// an Avalon slave model with random stalls/latency, and an in-order response monitor.
module tb_dbus_avm_bridge;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  dbus_avm_bridge_if bus();
  dbus_avm_bridge #(.MAX_PENDING(MAXP)) dut (.clk_cpu(clk), .clk_cpu_reset_(rstN), .bus(bus));

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } avmT;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rspT;

  int  errors = 0;
  int  checks = 0;
  avmT expAvm[$];
  rspT expRsp[$];
  rspT retQ[$];
  logic [31:0] refMem [int unsigned];
  logic [31:0] slvMem [int unsigned];
  int  waitProb = 0, retProb = 100, forceWait = 0, strayCount = 0, outstanding = 0;
  bit  holdReturns = 0;

  function automatic logic [31:0] initWord(input int unsigned w);
    return 32'(w * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction
  function automatic logic [31:0] refRead(input int unsigned w);
    return refMem.exists(w) ? refMem[w] : initWord(w);
  endfunction
  function automatic logic [31:0] slvRead(input int unsigned w);
    return slvMem.exists(w) ? slvMem[w] : initWord(w);
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Drive one command until accepted, then record what the bus and the CPU must see.
  task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data);
    bit rdy, legal;
    int n, nb;
    int unsigned w;
    logic [3:0]  be;
    logic [31:0] cur;
    bus.dBus_cmd_valid           = 1'b1;
    bus.dBus_cmd_payload_wr      = wr;
    bus.dBus_cmd_payload_size    = size;
    bus.dBus_cmd_payload_address = addr;
    bus.dBus_cmd_payload_data    = data;
    n = 0;
    forever begin
      rdy = bus.dBus_cmd_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 400) begin
        failNow("cmd_accept_timeout", "command never accepted, expected acceptance");
        bus.dBus_cmd_valid = 1'b0;
        return;
      end
    end
    bus.dBus_cmd_valid = 1'b0;
    bus.dBus_cmd_payload_address = $urandom;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    legal = (size != 2'd3) && ((addr % nb) == 0);
    w     = addr >> 2;
    if (legal) begin
      be = 4'b0000;
      for (int k = 0; k < nb; k++) be[int'(addr[1:0]) + k] = 1'b1;
      expAvm.push_back({wr, addr[31:2], 2'b00, be, data});
      if (wr) begin
        cur = refRead(w);
        for (int k = 0; k < 4; k++) if (be[k]) cur[8*k +: 8] = data[8*k +: 8];
        refMem[w] = cur;
      end else begin
        expRsp.push_back({addr[31:28] == 4'hE, refRead(w)});
      end
    end else if (!wr) begin
      expRsp.push_back({1'b1, 32'h0});
    end
  endtask

  task automatic randCmd();
    logic [1:0]  size;
    logic [31:0] addr, data;
    bit wr;
    size = 2'($urandom_range(0, 3));
    addr = (($urandom_range(0, 3) == 0) ? 32'hE000_0000 : 32'h0) | 32'($urandom_range(0, 63));
    data = $urandom;
    if (size == 2'd0) data = {4{data[7:0]}};
    if (size == 2'd1) data = {2{data[15:0]}};
    wr = 1'($urandom_range(0, 1));
    issue(wr, size, addr, data);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expRsp.size() != 0 || expAvm.size() != 0 || retQ.size() != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) failNow("drain_timeout", "outstanding work never completed");
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Avalon slave: random/forced stalls, in-order read returns, payload-stability checks.
  initial begin
    avmT cur, prevTxn, e;
    bit  prevStall, stall;
    rspT r;
    int unsigned w;
    logic [31:0] m;
    prevStall = 0;
    prevTxn   = '0;
    bus.avm_data_waitrequest   = 1'b0;
    bus.avm_data_readdatavalid = 1'b0;
    bus.avm_data_readdata      = '0;
    bus.avm_data_response      = 2'b00;
    forever begin
      @(negedge clk);
      if (rstN && outstanding >= MAXP) begin
        if (outstanding > MAXP) failNow("pending_bound", "more reads outstanding than allowed");
        chk("full_blocks_cmd", 72'(bus.dBus_cmd_ready), 72'(0));
      end
      if (strayCount > 0) begin
        bus.avm_data_readdatavalid = 1'b1;
        bus.avm_data_readdata      = 32'h1234_5678;
        bus.avm_data_response      = 2'b00;
        strayCount--;
      end else if (retQ.size() > 0 && !holdReturns && $urandom_range(0, 99) < retProb) begin
        r = retQ.pop_front();
        bus.avm_data_readdatavalid = 1'b1;
        bus.avm_data_readdata      = r.data;
        bus.avm_data_response      = r.err ? 2'b10 : 2'b00;
        outstanding--;
      end else begin
        bus.avm_data_readdatavalid = 1'b0;
        bus.avm_data_readdata      = $urandom;
        bus.avm_data_response      = 2'b00;
      end
      if (!rstN) begin
        prevStall = 0;
        bus.avm_data_waitrequest = 1'b0;
      end else if (bus.avm_data_read || bus.avm_data_write) begin
        cur = {bus.avm_data_write, bus.avm_data_address, bus.avm_data_byteenable,
               bus.avm_data_writedata};
        if (bus.avm_data_read && bus.avm_data_write) failNow("rd_wr_both", "read and write together");
        if (prevStall) chk("payload_stable", 72'(cur), 72'(prevTxn));
        stall = (forceWait > 0) ? 1'b1 : ($urandom_range(0, 99) < waitProb);
        if (forceWait > 0) forceWait--;
        bus.avm_data_waitrequest = stall;
        if (!stall) begin
          if (expAvm.size() == 0) begin
            failNow("unexpected_avm_cycle", $sformatf("got %0h expected no cycle", cur));
          end else begin
            e = expAvm.pop_front();
            chk("avm_txn", 72'(cur), 72'(e));
          end
          w = cur.addr >> 2;
          if (cur.wr) begin
            m = slvRead(w);
            for (int k = 0; k < 4; k++) if (cur.be[k]) m[8*k +: 8] = cur.wdata[8*k +: 8];
            slvMem[w] = m;
          end else begin
            retQ.push_back({cur.addr[31:28] == 4'hE, slvRead(w)});
            outstanding++;
          end
        end
        prevStall = stall;
        prevTxn   = cur;
      end else begin
        if (prevStall) failNow("strobe_dropped", "strobe released while stalled");
        prevStall = 0;
        bus.avm_data_waitrequest = 1'(($urandom_range(0, 1)));
      end
    end
  end

  // Response monitor: every dBus response must match the oldest expected one.
  initial begin
    rspT e;
    forever begin
      @(negedge clk);
      if (bus.dBus_rsp_ready === 1'b1) begin
        if (expRsp.size() == 0) begin
          failNow("unexpected_rsp", $sformatf("got err=%b data=%h expected no response",
                  bus.dBus_rsp_error, bus.dBus_rsp_data));
        end else begin
          e = expRsp.pop_front();
          chk("rsp", 72'({bus.dBus_rsp_error, bus.dBus_rsp_data}), 72'(e));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dBus_cmd_valid           = 1'b0;
    bus.dBus_cmd_payload_wr      = 1'b0;
    bus.dBus_cmd_payload_size    = 2'd0;
    bus.dBus_cmd_payload_address = '0;
    bus.dBus_cmd_payload_data    = '0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk); #1;
    chk("reset_cmd_ready", 72'(bus.dBus_cmd_ready), 72'(1));
    chk("reset_strobes", 72'({bus.avm_data_read, bus.avm_data_write}), 72'(0));
    chk("reset_rsp", 72'({bus.dBus_rsp_ready, bus.dBus_rsp_error, bus.dBus_rsp_data}), 72'(0));

    // Word read 0x100 with immediate return
    refMem[32'h40] = 32'hDEAD_BEEF;
    slvMem[32'h40] = 32'hDEAD_BEEF;
    issue(1'b0, 2'd2, 32'h100, $urandom);
    @(negedge clk); #1;
    chk("word_rd_strobe", 72'({bus.avm_data_read, bus.avm_data_address, bus.avm_data_byteenable}),
        72'({1'b1, 32'h100, 4'hF}));
    @(negedge clk); #1;
    chk("word_rd_rsp_not_early", 72'(bus.dBus_rsp_ready), 72'(0));
    @(negedge clk); #1;
    chk("word_rd_rsp", 72'({bus.dBus_rsp_ready, bus.dBus_rsp_error, bus.dBus_rsp_data}),
        72'({2'b10, 32'hDEAD_BEEF}));
    drain();

    // Byte write 0x203 stalled for three cycles
    forceWait = 3;
    issue(1'b1, 2'd0, 32'h203, 32'hAAAA_AAAA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("bytewr_payload", 72'({bus.avm_data_write, bus.avm_data_address, bus.avm_data_byteenable,
          bus.avm_data_writedata}), 72'({1'b1, 32'h200, 4'b1000, 32'hAAAA_AAAA}));
      chk("bytewr_cmd_ready_low", 72'(bus.dBus_cmd_ready), 72'(0));
    end
    @(negedge clk); #1;
    chk("bytewr_done", 72'({bus.avm_data_write, bus.dBus_cmd_ready}), 72'({1'b0, 1'b1}));
    drain();

    // Fill the outstanding-read window, then a fifth read
    holdReturns = 1;
    for (int i = 0; i < MAXP; i++) issue(1'b0, 2'd2, 32'(i * 4), $urandom);
    repeat (2) @(negedge clk); #1;
    chk("full_ready_low", 72'(bus.dBus_cmd_ready), 72'(0));
    fork
      issue(1'b0, 2'd2, 32'h10, $urandom);
      begin
        repeat (5) @(negedge clk);
        #1 chk("full_ready_still_low", 72'(bus.dBus_cmd_ready), 72'(0));
        holdReturns = 0;
      end
    join
    drain();

    // Misaligned half read behind two outstanding reads
    holdReturns = 1;
    issue(1'b0, 2'd2, 32'h20, $urandom);
    issue(1'b0, 2'd2, 32'h24, $urandom);
    issue(1'b0, 2'd1, 32'h101, $urandom);
    repeat (4) @(negedge clk);
    #1 holdReturns = 0;
    drain();

    // Error response from the slave, then a dropped misaligned word write
    issue(1'b0, 2'd2, 32'hE000_0010, $urandom);
    drain();
    issue(1'b1, 2'd2, 32'h102, $urandom);
    @(negedge clk); #1;
    chk("bad_wr_no_strobe", 72'({bus.avm_data_read, bus.avm_data_write}), 72'(0));
    chk("bad_wr_ready", 72'(bus.dBus_cmd_ready), 72'(1));
    drain();

    // Randomized traffic
    waitProb = 30;
    retProb  = 40;
    for (int i = 0; i < 300; i++) randCmd();
    drain();

    // Reset in the middle of a stalled read, with another read outstanding
    waitProb    = 0;
    retProb     = 100;
    holdReturns = 1;
    issue(1'b0, 2'd2, 32'h30, $urandom);
    forceWait = 50;
    issue(1'b0, 2'd2, 32'h34, $urandom);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("rst_strobes_drop", 72'({bus.avm_data_read, bus.avm_data_write}), 72'(0));
    chk("rst_rsp_low", 72'(bus.dBus_rsp_ready), 72'(0));
    expAvm.delete();
    expRsp.delete();
    retQ.delete();
    outstanding = 0;
    forceWait   = 0;
    holdReturns = 0;
    @(negedge clk);
    #2 rstN = 1'b1;
    strayCount = 1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("stray_no_rsp", 72'(bus.dBus_rsp_ready), 72'(0));
    end
    chk("post_rst_ready", 72'(bus.dBus_cmd_ready), 72'(1));
    holdReturns = 1;
    for (int i = 0; i < MAXP; i++) issue(1'b0, 2'd2, 32'(8'h40 + i * 4), $urandom);
    repeat (2) @(negedge clk); #1;
    chk("post_rst_full", 72'(bus.dBus_cmd_ready), 72'(0));
    holdReturns = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
